// File: rtl/writeback_unit.sv
// writeback_unit: result select, load align/extend, in-order retire queue and register-file write handshake
module writeback_unit #(
  parameter int WORD_SIZE = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int QUEUE_DEPTH = 2,
  parameter int RETIRE_CNT_BITS = 64,
  localparam int OFS_BITS = $clog2(WORD_SIZE / 8),
  localparam int CNT_BITS = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [REG_ADDR_BITS-1:0]   in_rd_addr,
  input  logic                       in_rd_we,
  input  logic [1:0]                 in_src_sel,
  input  logic [WORD_SIZE-1:0]       in_alu_result,
  input  logic [WORD_SIZE-1:0]       in_load_data,
  input  logic [WORD_SIZE-1:0]       in_pc_plus4,
  input  logic [WORD_SIZE-1:0]       in_csr_data,
  input  logic [2:0]                 in_load_funct3,
  input  logic [OFS_BITS-1:0]        in_load_offset,
  input  logic                       write_grant,
  output logic                       write_enable_out,
  output logic [REG_ADDR_BITS-1:0]   write_addr,
  output logic [WORD_SIZE-1:0]       write_data,
  output logic                       fwd_valid,
  output logic [REG_ADDR_BITS-1:0]   fwd_addr,
  output logic [WORD_SIZE-1:0]       fwd_data,
  output logic [CNT_BITS-1:0]        queue_count,
  output logic [RETIRE_CNT_BITS-1:0] retire_count
);
  localparam int PTR_BITS = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [PTR_BITS-1:0] LAST = PTR_BITS'(QUEUE_DEPTH - 1);
  logic [REG_ADDR_BITS-1:0] q_addr [QUEUE_DEPTH];
  logic                     q_we   [QUEUE_DEPTH];
  logic [WORD_SIZE-1:0]     q_data [QUEUE_DEPTH];
  logic [PTR_BITS-1:0] head, tail, young;
  logic push, pop, we_eff;
  logic [WORD_SIZE-1:0] shifted, load_val, push_data;
  assign shifted = in_load_data >> {in_load_offset, 3'b000};
  always_comb begin
    load_val = WORD_SIZE'($signed(shifted[31:0]));
    case (in_load_funct3)
      3'b000: load_val = WORD_SIZE'($signed(shifted[7:0]));
      3'b001: load_val = WORD_SIZE'($signed(shifted[15:0]));
      3'b100: load_val = WORD_SIZE'(shifted[7:0]);
      3'b101: load_val = WORD_SIZE'(shifted[15:0]);
      3'b110: load_val = WORD_SIZE'(shifted[31:0]);
      3'b011: load_val = WORD_SIZE == 64 ? shifted : WORD_SIZE'($signed(shifted[31:0]));
      default: load_val = WORD_SIZE'($signed(shifted[31:0]));
    endcase
  end
  assign push_data = in_src_sel == 2'd1 ? load_val :
                     in_src_sel == 2'd2 ? in_pc_plus4 :
                     in_src_sel == 2'd3 ? in_csr_data : in_alu_result;
  assign we_eff = in_rd_we && |in_rd_addr;
  assign in_ready = reset_n && queue_count < CNT_BITS'(QUEUE_DEPTH);
  assign push = in_valid && in_ready;
  // non-writing heads retire without waiting for the shared write port
  assign pop = |queue_count && (write_grant || !q_we[head]);
  assign young = tail == '0 ? LAST : tail - PTR_BITS'(1);
  assign fwd_valid = reset_n && |queue_count && q_we[young];
  assign fwd_addr = fwd_valid ? q_addr[young] : '0;
  assign fwd_data = fwd_valid ? q_data[young] : '0;
  always_ff @(posedge clock) begin
    if (push) begin
      q_addr[tail] <= in_rd_addr;
      q_we[tail] <= we_eff;
      q_data[tail] <= push_data;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      queue_count <= '0;
      write_enable_out <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      retire_count <= '0;
    end else begin
      if (push) tail <= tail == LAST ? '0 : tail + PTR_BITS'(1);
      if (pop) head <= head == LAST ? '0 : head + PTR_BITS'(1);
      queue_count <= queue_count + CNT_BITS'(push) - CNT_BITS'(pop);
      write_enable_out <= pop && q_we[head];
      if (pop) begin
        write_addr <= q_addr[head];
        write_data <= q_data[head];
        retire_count <= retire_count + RETIRE_CNT_BITS'(1);
      end
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed self-checking bench for writeback_unit with default parameters
module tb_writeback_unit;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [4:0] in_rd_addr = '0;
  logic in_rd_we = 1'b0;
  logic [1:0] in_src_sel = '0;
  logic [31:0] in_alu_result = '0, in_load_data = '0, in_pc_plus4 = '0, in_csr_data = '0;
  logic [2:0] in_load_funct3 = '0;
  logic [1:0] in_load_offset = '0;
  logic write_grant = 1'b0;
  logic write_enable_out;
  logic [4:0] write_addr;
  logic [31:0] write_data;
  logic fwd_valid;
  logic [4:0] fwd_addr;
  logic [31:0] fwd_data;
  logic [1:0] queue_count;
  logic [63:0] retire_count;
  int checks = 0;
  int errors = 0;

  writeback_unit dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .in_src_sel(in_src_sel),
    .in_alu_result(in_alu_result), .in_load_data(in_load_data), .in_pc_plus4(in_pc_plus4),
    .in_csr_data(in_csr_data), .in_load_funct3(in_load_funct3), .in_load_offset(in_load_offset),
    .write_grant(write_grant), .write_enable_out(write_enable_out), .write_addr(write_addr),
    .write_data(write_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .queue_count(queue_count), .retire_count(retire_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic we, input logic [1:0] sel, input logic [31:0] val);
    in_valid = 1'b1;
    in_rd_addr = rd;
    in_rd_we = we;
    in_src_sel = sel;
    in_alu_result = sel == 2'd0 ? val : 32'h0;
    in_pc_plus4 = sel == 2'd2 ? val : 32'h0;
    in_csr_data = sel == 2'd3 ? val : 32'h0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (write_enable_out !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_write: we=%b addr=%0d data=%h, required 0/0/0", write_enable_out, write_addr, write_data);
    end
    checks++;
    if (retire_count !== 64'd0 || queue_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_counts: retire=%0d count=%0d, required 0/0", retire_count, queue_count);
    end
    checks++;
    if (in_ready !== 1'b0 || fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready=%b fwd_valid=%b, required 0/0", in_ready, fwd_valid);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_alu();
    write_grant = 1'b1;
    drive(5'd5, 1'b1, 2'd0, 32'h1234_5678);
    #0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL alu_ready: got %b, required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (write_enable_out !== 1'b0 || queue_count !== 2'd1 || fwd_valid !== 1'b1 || fwd_addr !== 5'd5 || fwd_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alu_queued: we=%b count=%0d fwd=%b/%0d/%h, required 0/1/1/5/12345678", write_enable_out, queue_count, fwd_valid, fwd_addr, fwd_data);
    end
    tick();
    checks++;
    if (write_enable_out !== 1'b1 || write_addr !== 5'd5 || write_data !== 32'h1234_5678 || retire_count !== 64'd1) begin
      errors++;
      $display("FAIL alu_write: we=%b addr=%0d data=%h retire=%0d, required 1/5/12345678/1", write_enable_out, write_addr, write_data, retire_count);
    end
    tick();
    checks++;
    if (write_enable_out !== 1'b0 || write_addr !== 5'd5 || write_data !== 32'h1234_5678 || queue_count !== 2'd0) begin
      errors++;
      $display("FAIL alu_pulse: we=%b addr=%0d data=%h count=%0d, required 0/5/12345678/0", write_enable_out, write_addr, write_data, queue_count);
    end
  endtask

  task automatic test_loads();
    logic [2:0] f3 [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b011, 3'b111};
    logic [1:0] ofs [8] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
    logic [31:0] exp [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                             32'h80FF_7F01, 32'h0000_007F, 32'h80FF_7F01, 32'h80FF_7F01};
    write_grant = 1'b1;
    in_load_data = 32'h80FF_7F01;
    for (int i = 0; i < 8; i++) begin
      drive(5'(10 + i), 1'b1, 2'd1, 32'h0);
      in_load_funct3 = f3[i];
      in_load_offset = ofs[i];
      tick();
      in_valid = 1'b0;
      checks++;
      if (fwd_data !== exp[i] || fwd_addr !== 5'(10 + i)) begin
        errors++;
        $display("FAIL load_fwd[%0d]: funct3=%b ofs=%0d got %h rd=%0d, required %h rd=%0d", i, f3[i], ofs[i], fwd_data, fwd_addr, exp[i], 10 + i);
      end
      tick();
      checks++;
      if (write_enable_out !== 1'b1 || write_data !== exp[i]) begin
        errors++;
        $display("FAIL load_write[%0d]: we=%b data=%h, required 1/%h", i, write_enable_out, write_data, exp[i]);
      end
    end
  endtask

  task automatic test_rd0();
    do_reset();
    write_grant = 1'b1;
    drive(5'd0, 1'b1, 2'd0, 32'hDEAD_BEEF);
    tick();
    checks++;
    if (fwd_valid !== 1'b0 || fwd_addr !== 5'd0 || fwd_data !== 32'd0 || queue_count !== 2'd1) begin
      errors++;
      $display("FAIL rd0_fwd: fwd=%b/%0d/%h count=%0d, required 0/0/0/1", fwd_valid, fwd_addr, fwd_data, queue_count);
    end
    drive(5'd1, 1'b1, 2'd2, 32'h0000_0104);
    tick();
    in_valid = 1'b0;
    checks++;
    if (write_enable_out !== 1'b0 || queue_count !== 2'd1 || fwd_addr !== 5'd1 || retire_count !== 64'd1) begin
      errors++;
      $display("FAIL rd0_nowrite: we=%b count=%0d fwd_addr=%0d retire=%0d, required 0/1/1/1", write_enable_out, queue_count, fwd_addr, retire_count);
    end
    tick();
    checks++;
    if (write_enable_out !== 1'b1 || write_addr !== 5'd1 || write_data !== 32'h104 || retire_count !== 64'd2) begin
      errors++;
      $display("FAIL rd0_link: we=%b addr=%0d data=%h retire=%0d, required 1/1/104/2", write_enable_out, write_addr, write_data, retire_count);
    end
  endtask

  task automatic test_stall();
    logic [4:0] ea [3] = '{5'd2, 5'd3, 5'd4};
    logic [31:0] ed [3] = '{32'hA, 32'hB, 32'hC};
    do_reset();
    write_grant = 1'b0;
    drive(5'd2, 1'b1, 2'd0, 32'hA);
    tick();
    drive(5'd3, 1'b1, 2'd3, 32'hB);
    checks++;
    if (in_ready !== 1'b1 || queue_count !== 2'd1) begin
      errors++;
      $display("FAIL stall_one: ready=%b count=%0d, required 1/1", in_ready, queue_count);
    end
    tick();
    drive(5'd4, 1'b1, 2'd0, 32'hC);
    checks++;
    if (in_ready !== 1'b0 || queue_count !== 2'd2 || fwd_addr !== 5'd3 || fwd_data !== 32'hB) begin
      errors++;
      $display("FAIL stall_full: ready=%b count=%0d fwd=%0d/%h, required 0/2/3/b", in_ready, queue_count, fwd_addr, fwd_data);
    end
    tick();
    checks++;
    if (in_ready !== 1'b0 || queue_count !== 2'd2 || write_enable_out !== 1'b0 || retire_count !== 64'd0) begin
      errors++;
      $display("FAIL stall_hold: ready=%b count=%0d we=%b retire=%0d, required 0/2/0/0", in_ready, queue_count, write_enable_out, retire_count);
    end
    write_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 1) in_valid = 1'b0;
      checks++;
      if (write_enable_out !== 1'b1 || write_addr !== ea[i] || write_data !== ed[i]) begin
        errors++;
        $display("FAIL stall_drain[%0d]: we=%b addr=%0d data=%h, required 1/%0d/%h", i, write_enable_out, write_addr, write_data, ea[i], ed[i]);
      end
      if (i == 0) begin
        checks++;
        if (in_ready !== 1'b1 || queue_count !== 2'd1) begin
          errors++;
          $display("FAIL stall_reopen: ready=%b count=%0d, required 1/1", in_ready, queue_count);
        end
      end
    end
    checks++;
    if (retire_count !== 64'd3 || queue_count !== 2'd0) begin
      errors++;
      $display("FAIL stall_end: retire=%0d count=%0d, required 3/0", retire_count, queue_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    write_grant = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(5'(i + 1), 1'b1, 2'd0, 32'h100 + 32'(i));
      tick();
      checks++;
      if (queue_count > 2'd1 || (i > 0 && (write_enable_out !== 1'b1 || write_addr !== 5'(i) || write_data !== 32'h100 + 32'(i - 1)))) begin
        errors++;
        $display("FAIL b2b[%0d]: count=%0d we=%b addr=%0d data=%h, required <=1/1/%0d/%h", i, queue_count, write_enable_out, write_addr, write_data, i, 32'h100 + 32'(i - 1));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (write_enable_out !== 1'b1 || write_addr !== 5'd10 || write_data !== 32'h109 || retire_count !== 64'd10) begin
      errors++;
      $display("FAIL b2b_last: we=%b addr=%0d data=%h retire=%0d, required 1/10/109/10", write_enable_out, write_addr, write_data, retire_count);
    end
  endtask

  task automatic test_reset_mid();
    write_grant = 1'b0;
    drive(5'd7, 1'b1, 2'd0, 32'h77);
    tick();
    drive(5'd8, 1'b1, 2'd0, 32'h88);
    tick();
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_comb: ready=%b fwd_valid=%b, required 0/0", in_ready, fwd_valid);
    end
    tick();
    checks++;
    if (write_enable_out !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'd0 || retire_count !== 64'd0 || queue_count !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset: we=%b addr=%0d data=%h retire=%0d count=%0d, required all 0", write_enable_out, write_addr, write_data, retire_count, queue_count);
    end
    reset_n = 1'b1;
    write_grant = 1'b1;
    tick();
    checks++;
    if (write_enable_out !== 1'b0 || queue_count !== 2'd0 || retire_count !== 64'd0) begin
      errors++;
      $display("FAIL mid_discard: we=%b count=%0d retire=%0d, required 0/0/0", write_enable_out, queue_count, retire_count);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_rd0();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Parametrised writeback stage with result selection, load alignment/extension, an in-order retire queue and a handshake to a shared register-file write port. Sits between the memory/execute stage and the register file in the decode stage, replacing the fixed single-latch writeback. Issues at most one register write per cycle and counts retired instructions.

## Interface
- WORD_SIZE, 32: datapath width; 32 or 64.
- REG_ADDR_BITS, 5: register index width.
- QUEUE_DEPTH, 2: retire queue entries; ≥1.
- RETIRE_CNT_BITS, 64: width of retire counter.
- OFS_BITS (derived): $clog2(WORD_SIZE/8), load byte-offset width.

- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  unit accepts this cycle.
- in_rd_addr  in  REG_ADDR_BITS  destination register.
- in_rd_we  in  1  instruction writes a register.
- in_src_sel  in  2  0 ALU, 1 load, 2 link (PC+4), 3 CSR.
- in_alu_result, in_load_data, in_pc_plus4, in_csr_data  in  WORD_SIZE each  result sources.
- in_load_funct3  in  3  load type.
- in_load_offset  in  OFS_BITS  byte address low bits of the load.
- write_grant  in  1  register-file write port available this cycle.
- write_enable_out  out  1  register-file write strobe.
- write_addr  out  REG_ADDR_BITS  register-file write index.
- write_data  out  WORD_SIZE  register-file write data.
- fwd_valid  out  1  youngest queued entry will write a register.
- fwd_addr  out  REG_ADDR_BITS; fwd_data  out  WORD_SIZE  its index and data.
- queue_count  out  $clog2(QUEUE_DEPTH+1)  occupied entries.
- retire_count  out  RETIRE_CNT_BITS  instructions retired since reset.

## Operation
- Accept: in_valid && in_ready at a posedge pushes one entry {addr, we_eff, data}. in_ready = reset_n && (queue_count < QUEUE_DEPTH); no push into a full queue even if popping that cycle.
- we_eff = in_rd_we && (in_rd_addr != 0). Entries with we_eff=0 still enqueue to keep retire order.
- data computed at push: sel 0/2/3 pass the source. sel 1: shift in_load_data right by 8*in_load_offset, then funct3: 000 LB sign-ext 8; 001 LH sign-ext 16; 010 LW sign-ext 32; 100 LBU zero-ext 8; 101 LHU zero-ext 16; 110 LWU zero-ext 32; 011 LD full word (WORD_SIZE=64 only); any other code treated as 010. Misaligned offsets are not checked; shifted-out bits are dropped.
- Pop: head retires at a posedge if queue non-empty and (write_grant || !head.we_eff). Retiring registers write_enable_out = head.we_eff, write_addr/write_data = head fields; otherwise write_enable_out = 0 and addr/data hold.
- retire_count += 1 per pop (including non-writing entries); wraps modulo 2^RETIRE_CNT_BITS.
- Push and pop in the same cycle: count unchanged, order preserved (FIFO, circular pointers wrap at QUEUE_DEPTH).
- fwd_*: combinational from the youngest queued entry; fwd_valid = non-empty && youngest.we_eff; else fwd_valid=0 and addr/data 0.

## Timing
- Reset (reset_n low at posedge): queue emptied, write_enable_out 0, write_addr 0, write_data 0, retire_count 0, queue_count 0; in_ready 0 and fwd_valid 0 combinationally while reset_n low. Reset mid-operation discards queued entries; no write issued for them.
- Latency: entry pushed at edge E is eligible at edge E+1; with write_grant high, write_enable_out/addr/data valid from E+1 to E+2, register file writes at E+2. write_enable_out is a one-cycle pulse per write.
- write_grant low stalls only writing heads; queue fills, in_ready drops the cycle queue_count reaches QUEUE_DEPTH, rises the cycle after the first pop.
- Throughput: one retire per cycle with write_grant held high; QUEUE_DEPTH=1 sustains half rate.
- No negedge logic; all outputs change only after posedge.

## Test plan
- Reset then ALU push rd=5, data 0x1234_5678, grant high -> write_enable_out=1, addr 5, data 0x12345678 exactly one cycle, edge E+1; retire_count=1.
- Loads, load_data 0x80FF_7F01: LB ofs 3 -> 0xFFFFFF80; LBU ofs 3 -> 0x00000080; LH ofs 2 -> 0xFFFF80FF; LHU ofs 0 -> 0x00007F01; LW -> 0x80FF7F01.
- rd=0 with rd_we=1, then sel 2 rd=1 pc_plus4 0x104 -> no strobe for first, second writes x1=0x104; retire_count=2.
- write_grant low, 3 back-to-back pushes, DEPTH 2 -> in_ready low after second push, queue_count=2, no writes; grant high -> two writes in order then third accepted.
- Continuous push/pop with grant high for 10 cycles -> 10 writes in order, queue_count ≤1, retire_count=10.
- reset_n low with queue_count=2 -> no writes, all outputs zero next edge, retire_count 0.
